vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator with a pixel-fetch interface and a latency-compensating output pipeline.

---
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a pixel-fetch request stage and a
// latency-matched output pipeline so colour, syncs and DE stay aligned.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 88,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 13,
    parameter int V_SYNC      = 3,
    parameter int V_BP        = 32,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int COLOR_BITS  = 1,
    parameter int PIX_LATENCY = 1,
    parameter int CW          = 11
) (
    input  logic                    CLOCK_PIXEL,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic [3*COLOR_BITS-1:0] PIXEL_DATA,
    output logic                    PIXEL_REQ,
    output logic [CW-1:0]           PIXEL_H,
    output logic [CW-1:0]           PIXEL_V,
    output logic                    FRAME_START,
    output logic [COLOR_BITS-1:0]   VGA_RED,
    output logic [COLOR_BITS-1:0]   VGA_GREEN,
    output logic [COLOR_BITS-1:0]   VGA_BLUE,
    output logic                    VGA_HS,
    output logic                    VGA_VS,
    output logic                    VGA_DE
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0]           r_h;
    logic [CW-1:0]           r_v;
    logic                    r_frame_en;
    logic [2:0]              r_req_sync;
    logic [2:0]              r_dl [PIX_LATENCY+1];
    logic [3*COLOR_BITS-1:0] r_rgb;

    logic w_h_last;
    logic w_v_last;
    logic w_active;
    logic w_req;
    logic w_hs;
    logic w_vs;
    logic w_cap_de;

    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);
    assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_req    = r_frame_en && w_active;
    assign w_hs     = (r_h >= HS_BEG) && (r_h <= HS_END);
    assign w_vs     = (r_v >= VS_BEG) && (r_v <= VS_END);

    // Counters free-run; frame_en only changes at the last raster position
    always_ff @(posedge CLOCK_PIXEL) begin
        if (RESET) begin
            r_h        <= '0;
            r_v        <= '0;
            r_frame_en <= ENABLE;
        end else begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
            if (w_h_last && w_v_last) begin
                r_frame_en <= ENABLE;
            end
        end
    end

    always_ff @(posedge CLOCK_PIXEL) begin
        if (RESET) begin
            PIXEL_REQ   <= 1'b0;
            PIXEL_H     <= '0;
            PIXEL_V     <= '0;
            FRAME_START <= 1'b0;
            r_req_sync  <= 3'b000;
        end else begin
            PIXEL_REQ   <= w_req;
            PIXEL_H     <= w_req ? r_h : '0;
            PIXEL_V     <= w_req ? r_v : '0;
            FRAME_START <= (r_h == '0) && (r_v == '0);
            r_req_sync  <= {w_hs, w_vs, w_req};
        end
    end

    // Bits are {hs, vs, de}, held as "asserted" and mapped to pin polarity at the output
    always_ff @(posedge CLOCK_PIXEL) begin
        if (RESET) begin
            for (int i = 0; i < PIX_LATENCY + 1; i++) begin
                r_dl[i] <= 3'b000;
            end
        end else begin
            r_dl[0] <= r_req_sync;
            for (int i = 1; i < PIX_LATENCY + 1; i++) begin
                r_dl[i] <= r_dl[i-1];
            end
        end
    end

    generate
        if (PIX_LATENCY == 0) begin : g_cap_direct
            assign w_cap_de = r_req_sync[0];
        end else begin : g_cap_delayed
            assign w_cap_de = r_dl[PIX_LATENCY-1][0];
        end
    endgenerate

    always_ff @(posedge CLOCK_PIXEL) begin
        if (RESET) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_cap_de ? PIXEL_DATA : '0;
        end
    end

    assign VGA_HS    = r_dl[PIX_LATENCY][2] ~^ HS_POL;
    assign VGA_VS    = r_dl[PIX_LATENCY][1] ~^ VS_POL;
    assign VGA_DE    = r_dl[PIX_LATENCY][0];
    assign VGA_RED   = r_rgb[3*COLOR_BITS-1:2*COLOR_BITS];
    assign VGA_GREEN = r_rgb[2*COLOR_BITS-1:COLOR_BITS];
    assign VGA_BLUE  = r_rgb[COLOR_BITS-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny raster (8x5) with 4-bit colour,
// two-cycle pixel latency and active-low syncs.
module tb_vga_timing_gen;

    typedef struct {
        logic en_start;
        int   chg_line;
        logic en_chg;
        logic exp_en;
    } frame_vec_t;

    logic        clk;
    logic        RESET;
    logic        ENABLE;
    logic [11:0] PIXEL_DATA;
    logic        PIXEL_REQ;
    logic [3:0]  PIXEL_H;
    logic [3:0]  PIXEL_V;
    logic        FRAME_START;
    logic [3:0]  VGA_RED;
    logic [3:0]  VGA_GREEN;
    logic [3:0]  VGA_BLUE;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_DE;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .COLOR_BITS(4), .PIX_LATENCY(2), .CW(4)
    ) dut (
        .CLOCK_PIXEL(clk),
        .RESET(RESET),
        .ENABLE(ENABLE),
        .PIXEL_DATA(PIXEL_DATA),
        .PIXEL_REQ(PIXEL_REQ),
        .PIXEL_H(PIXEL_H),
        .PIXEL_V(PIXEL_V),
        .FRAME_START(FRAME_START),
        .VGA_RED(VGA_RED),
        .VGA_GREEN(VGA_GREEN),
        .VGA_BLUE(VGA_BLUE),
        .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS),
        .VGA_DE(VGA_DE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pix(input logic [3:0] h, input logic [3:0] v);
        return {h, v, ~h};
    endfunction

    // Pixel source: answers a request two cycles later, junk otherwise
    logic [11:0] d1, d2;
    initial begin
        d1 = 12'hF0A;
        d2 = 12'hF0A;
    end
    always @(posedge clk) begin
        d1 <= PIXEL_REQ ? pix(PIXEL_H, PIXEL_V) : 12'hF0A;
        d2 <= d1;
    end
    assign PIXEL_DATA = d2;

    frame_vec_t tab [8];
    logic       exp_en_q [16];
    logic       col_hs [8];
    logic       row_vs [5];
    int         c;
    int         fbase;
    int         n_pass;
    int         n_tot;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s c=%0d fb=%0d got %0h want %0h", nm, c, fbase, act, exp);
    endtask

    task automatic check_cycle();
        int p, q, h, v;
        logic en;
        logic e_req, e_fs, e_hs, e_vs, e_de;
        logic [3:0] e_h, e_v;
        logic [11:0] e_rgb;
        p = c - 1;
        q = c - 4;
        e_req = 1'b0; e_fs = 1'b0; e_h = 4'd0; e_v = 4'd0;
        if (p >= 0) begin
            h = (p % 40) % 8;
            v = (p % 40) / 8;
            en = exp_en_q[fbase + p / 40];
            e_req = en && (h < 4) && (v < 2);
            e_fs = ((p % 40) == 0);
            e_h = e_req ? 4'(h) : 4'd0;
            e_v = e_req ? 4'(v) : 4'd0;
        end
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 12'h000;
        if (q >= 0) begin
            h = (q % 40) % 8;
            v = (q % 40) / 8;
            en = exp_en_q[fbase + q / 40];
            e_hs = col_hs[h];
            e_vs = row_vs[v];
            e_de = en && (h < 4) && (v < 2);
            e_rgb = e_de ? pix(4'(h), 4'(v)) : 12'h000;
        end
        chk("req", 32'(PIXEL_REQ), 32'(e_req));
        chk("frame_start", 32'(FRAME_START), 32'(e_fs));
        chk("pixel_h", 32'(PIXEL_H), 32'(e_h));
        chk("pixel_v", 32'(PIXEL_V), 32'(e_v));
        chk("hs", 32'(VGA_HS), 32'(e_hs));
        chk("vs", 32'(VGA_VS), 32'(e_vs));
        chk("de", 32'(VGA_DE), 32'(e_de));
        chk("rgb", 32'({VGA_RED, VGA_GREEN, VGA_BLUE}), 32'(e_rgb));
    endtask

    initial begin
        int first_req, first_de, n_de, n_hs, n_vs;
        tab[0] = '{1'b1, -1, 1'b0, 1'b1};
        tab[1] = '{1'b1,  1, 1'b0, 1'b1};
        tab[2] = '{1'b0,  2, 1'b1, 1'b0};
        tab[3] = '{1'b1, -1, 1'b0, 1'b1};
        tab[4] = '{1'b1,  4, 1'b0, 1'b1};
        tab[5] = '{1'b0, -1, 1'b0, 1'b0};
        tab[6] = '{1'b0,  0, 1'b1, 1'b0};
        tab[7] = '{1'b1, -1, 1'b0, 1'b1};
        col_hs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        row_vs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) exp_en_q[i] = 1'b1;
        for (int i = 0; i < 8; i++) exp_en_q[i] = tab[i].exp_en;
        exp_en_q[9] = 1'b0;
        n_pass = 0; n_tot = 0; c = 0; fbase = 0;
        first_req = -1; first_de = -1; n_de = 0; n_hs = 0; n_vs = 0;

        RESET = 1'b1;
        ENABLE = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        RESET = 1'b0;
        c = 0;
        check_cycle();

        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 40; k++) begin
                if (k == 0) ENABLE = tab[f].en_start;
                if (tab[f].chg_line >= 0 && k == 8 * tab[f].chg_line) ENABLE = tab[f].en_chg;
                @(posedge clk);
                #1;
                c++;
                check_cycle();
                if (first_req < 0 && PIXEL_REQ) first_req = c;
                if (first_de < 0 && VGA_DE) first_de = c;
                if (c >= 44 && c <= 83) begin
                    if (VGA_DE) n_de++;
                    if (!VGA_HS) n_hs++;
                    if (!VGA_VS) n_vs++;
                end
            end
        end
        chk("first_de_lag", 32'(first_de - first_req), 32'd3);
        chk("de_per_frame", 32'(n_de), 32'd8);
        chk("hs_low_per_frame", 32'(n_hs), 32'd10);
        chk("vs_low_per_frame", 32'(n_vs), 32'd8);

        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            c++;
            check_cycle();
        end

        // Mid-frame reset with ENABLE low: first frame after release stays dark
        RESET = 1'b1;
        ENABLE = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rst_req", 32'(PIXEL_REQ), 32'd0);
            chk("rst_fs", 32'(FRAME_START), 32'd0);
            chk("rst_hs", 32'(VGA_HS), 32'd1);
            chk("rst_vs", 32'(VGA_VS), 32'd1);
            chk("rst_de", 32'(VGA_DE), 32'd0);
            chk("rst_rgb", 32'({VGA_RED, VGA_GREEN, VGA_BLUE}), 32'd0);
        end
        RESET = 1'b0;
        c = 0;
        fbase = 9;
        check_cycle();
        for (int k = 0; k < 85; k++) begin
            if (k == 5) ENABLE = 1'b1;
            @(posedge clk);
            #1;
            c++;
            check_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
